// File: rtl/bus_pkg.sv
// Shared types and constants for the two-core system bus arbiter.
package bus_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT0 = 3'd1,
        GRANT1 = 3'd2
    } bus_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter giving one of two cores exclusive access to the memory port.
module bus_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core0_request,
    output logic              core0_grant,
    input  logic [DATA_W-1:0] core0_data_in,
    output logic [DATA_W-1:0] core0_data_out,
    input  logic [ADDR_W-1:0] core0_address,
    input  logic              core0_rw,
    input  logic              core1_request,
    output logic              core1_grant,
    input  logic [DATA_W-1:0] core1_data_in,
    output logic [DATA_W-1:0] core1_data_out,
    input  logic [ADDR_W-1:0] core1_address,
    input  logic              core1_rw,
    output logic [ADDR_W-1:0] RAM_address,
    output logic [DATA_W-1:0] RAM_data_in,
    input  logic [DATA_W-1:0] RAM_data_out,
    output logic              rw
);
    import bus_pkg::*;

    bus_state_t state;
    bus_state_t next_state_s;
    logic       last;
    logic       next_last_s;

    // State and last-served registers; last=1 lets core0 win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= next_state_s;
            last  <= next_last_s;
        end
    end

    // Next-state logic: owner keeps the bus until it drops its request.
    always_comb begin
        next_state_s = IDLE;
        next_last_s  = last;
        case (state)
            IDLE: begin
                if (core0_request && core1_request) begin
                    if (last) begin
                        next_state_s = GRANT0;
                    end else begin
                        next_state_s = GRANT1;
                    end
                end else if (core0_request) begin
                    next_state_s = GRANT0;
                end else if (core1_request) begin
                    next_state_s = GRANT1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT0: begin
                if (core0_request) begin
                    next_state_s = GRANT0;
                end else begin
                    next_state_s = IDLE;
                    next_last_s  = 1'b0;
                end
            end
            GRANT1: begin
                if (core1_request) begin
                    next_state_s = GRANT1;
                end else begin
                    next_state_s = IDLE;
                    next_last_s  = 1'b1;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_last_s  = last;
            end
        endcase
    end

    // Grants and datapath steering, decoded purely from the current owner.
    always_comb begin
        core0_grant    = 1'b0;
        core1_grant    = 1'b0;
        RAM_address    = {ADDR_W{1'b0}};
        RAM_data_in    = {DATA_W{1'b0}};
        rw             = RW_READ;
        core0_data_out = {DATA_W{1'b0}};
        core1_data_out = {DATA_W{1'b0}};
        case (state)
            GRANT0: begin
                core0_grant    = 1'b1;
                RAM_address    = core0_address;
                RAM_data_in    = core0_data_in;
                rw             = core0_rw;
                core0_data_out = RAM_data_out;
            end
            GRANT1: begin
                core1_grant    = 1'b1;
                RAM_address    = core1_address;
                RAM_data_in    = core1_data_in;
                rw             = core1_rw;
                core1_data_out = RAM_data_out;
            end
            default: begin
                core0_grant = 1'b0;
                core1_grant = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       core0_request, core1_request;
    logic       core0_grant, core1_grant;
    logic [7:0] core0_data_in, core1_data_in;
    logic [7:0] core0_data_out, core1_data_out;
    logic [8:0] core0_address, core1_address;
    logic       core0_rw, core1_rw;
    logic [8:0] RAM_address;
    logic [7:0] RAM_data_in;
    logic [7:0] RAM_data_out;
    logic       rw;

    int n_cmp = 0;
    int n_err = 0;

    bus_arbiter #(.ADDR_W(9), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .core0_request(core0_request), .core0_grant(core0_grant),
        .core0_data_in(core0_data_in), .core0_data_out(core0_data_out),
        .core0_address(core0_address), .core0_rw(core0_rw),
        .core1_request(core1_request), .core1_grant(core1_grant),
        .core1_data_in(core1_data_in), .core1_data_out(core1_data_out),
        .core1_address(core1_address), .core1_rw(core1_rw),
        .RAM_address(RAM_address), .RAM_data_in(RAM_data_in),
        .RAM_data_out(RAM_data_out), .rw(rw)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(dut.state), 32'd0);
        check({tag, "_grants"}, {30'd0, core1_grant, core0_grant}, 32'd0);
        check({tag, "_rw"}, 32'(rw), 32'd0);
        check({tag, "_addr"}, 32'(RAM_address), 32'd0);
        check({tag, "_wdata"}, 32'(RAM_data_in), 32'd0);
        check({tag, "_dout0"}, 32'(core0_data_out), 32'd0);
        check({tag, "_dout1"}, 32'(core1_data_out), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        core0_request = 1'b0; core1_request = 1'b0;
        core0_data_in = 8'h00; core1_data_in = 8'h00;
        core0_address = 9'd0;  core1_address = 9'd0;
        core0_rw = 1'b0; core1_rw = 1'b0;
        RAM_data_out = 8'h5A;
        step(); step();
        check_idle("reset");
        check("reset_last", 32'(dut.last), 32'd1);
        reset = 1'b0;

        // Single request from core0: one-edge grant latency, read data routed back
        core0_request = 1'b1; core0_address = 9'd504; core0_rw = 1'b0;
        RAM_data_out = 8'h04;
        #1;
        check("c0_pre_grant", 32'(core0_grant), 32'd0);
        step();
        check("c0_grant", {30'd0, core1_grant, core0_grant}, 32'd1);
        check("c0_state", 32'(dut.state), 32'd1);
        check("c0_addr", 32'(RAM_address), 32'd504);
        check("c0_dout0", 32'(core0_data_out), 32'h04);
        check("c0_dout1", 32'(core1_data_out), 32'h00);
        check("c0_rw_read", 32'(rw), 32'd0);

        // Asynchronous reset in the middle of a core0 write
        core0_rw = 1'b1; core0_data_in = 8'hAA;
        #1;
        check("c0_rw_write", 32'(rw), 32'd1);
        check("c0_wdata", 32'(RAM_data_in), 32'hAA);
        #1;
        reset = 1'b1;
        #1;
        check_idle("midreset");
        step();
        reset = 1'b0;
        core0_request = 1'b0;

        // Tie after reset goes to core0
        core0_rw = 1'b0; core0_address = 9'd5; core0_data_in = 8'hFF;
        core1_rw = 1'b1; core1_address = 9'd503; core1_data_in = 8'h01;
        core0_request = 1'b1; core1_request = 1'b1;
        step();
        check("tie1_state", 32'(dut.state), 32'd1);
        check("tie1_grants", {30'd0, core1_grant, core0_grant}, 32'd1);
        core0_request = 1'b0;
        step();
        check("drop0_idle_state", 32'(dut.state), 32'd0);
        check("drop0_grants", {30'd0, core1_grant, core0_grant}, 32'd0);
        check("drop0_last", 32'(dut.last), 32'd0);
        step();
        check("g1_state", 32'(dut.state), 32'd2);
        check("g1_grants", {30'd0, core1_grant, core0_grant}, 32'd2);
        check("g1_rw", 32'(rw), 32'd1);
        check("g1_addr", 32'(RAM_address), 32'd503);
        check("g1_wdata", 32'(RAM_data_in), 32'h01);
        check("g1_dout0", 32'(core0_data_out), 32'h00);
        check("g1_dout1", 32'(core1_data_out), 32'h04);
        core1_address = 9'd511;
        #1;
        check("g1_addr511", 32'(RAM_address), 32'd511);

        // core0 waits behind core1, then wins the re-tie
        core0_request = 1'b1;
        step();
        check("g1_hold_state", 32'(dut.state), 32'd2);
        core1_request = 1'b0;
        step();
        check("drop1_idle_state", 32'(dut.state), 32'd0);
        check("drop1_last", 32'(dut.last), 32'd1);
        core1_request = 1'b1;
        step();
        check("rr_state", 32'(dut.state), 32'd1);
        check("rr_grants", {30'd0, core1_grant, core0_grant}, 32'd1);

        // No preemption while core0 holds for 100 cycles
        for (int i = 0; i < 100; i++) begin
            step();
            check("hold_grants", {30'd0, core1_grant, core0_grant}, 32'd1);
        end

        // Tie with last=0 must go to core1
        core0_request = 1'b0;
        step();
        check("tie2_idle", 32'(dut.state), 32'd0);
        core0_request = 1'b1;
        step();
        check("tie2_state", 32'(dut.state), 32'd2);
        check("tie2_grants", {30'd0, core1_grant, core0_grant}, 32'd2);

        // Quiet bus stays idle
        core0_request = 1'b0; core1_request = 1'b0;
        step();
        for (int i = 0; i < 50; i++) begin
            step();
            check("quiet_state", 32'(dut.state), 32'd0);
            check("quiet_rw", 32'(rw), 32'd0);
            check("quiet_grants", {30'd0, core1_grant, core0_grant}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Single-master-at-a-time system bus between two CPU cores and one 512-byte byte-wide GPIO/RAM memory.
- Each core raises a request and waits for its grant.
- The arbiter grants one core at a time, round-robin, and steers that core's address, write data and rw onto the memory port.
- Read data from memory goes back to the granted core only.
- Sits in the top level between core0/core1 and the gpiomem block.

Parameters:
- ADDR_W, 9, address width (512-byte space).
- DATA_W, 8, data width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- core0_request  input  1  core0 wants the bus; held high for the whole transaction sequence.
- core0_grant  output  1  core0 owns the bus.
- core0_data_in  input  DATA_W  write data from core0.
- core0_data_out  output  DATA_W  read data to core0.
- core0_address  input  ADDR_W  address from core0.
- core0_rw  input  1  core0 access type: 1 = write, 0 = read.
- core1_request, core1_grant, core1_data_in, core1_data_out, core1_address, core1_rw: identical meaning for core1.
- RAM_address  output  ADDR_W  address to memory.
- RAM_data_in  output  DATA_W  write data to memory.
- RAM_data_out  input  DATA_W  read data from memory.
- rw  output  1  memory access type: 1 = write, 0 = read.

Behaviour:
- State register `state` is 3 bits and hierarchically visible.
  - Encodings: IDLE=3'd0, GRANT0=3'd1, GRANT1=3'd2.
  - Other codes are illegal and return to IDLE on the next edge.
- Register `last` is 1 bit and holds the last core served.
- Reset (async, any time, including mid-transfer):
  - state=IDLE, last=1 (so core0 wins the first tie).
  - All grants 0, rw=0, RAM_address=0, RAM_data_in=0, both core data_out=0.
- IDLE transitions:
  - Only core0_request -> GRANT0.
  - Only core1_request -> GRANT1.
  - Both requesting -> the core not equal to `last`.
  - Neither requesting -> stay IDLE.
- GRANTn transitions:
  - Stay while coreN_request=1; no preemption and no timeout.
  - When coreN_request=0 -> IDLE and set last=n.
  - There is always one IDLE cycle between owners; no back-to-back handoff.
- Grant timing:
  - Grants are Moore outputs: coreN_grant=1 exactly when state==GRANTn.
  - At most one grant is high at any time.
  - Latency is 1 clock: a request sampled high in IDLE gives grant high after that edge.
- Datapath is combinational, driven from `state`:
  - GRANTn: RAM_address=coreN_address, RAM_data_in=coreN_data_in, rw=coreN_rw, coreN_data_out=RAM_data_out, other core's data_out=0.
  - IDLE: RAM_address=0, RAM_data_in=0, rw=0 (read, never writes), both data_out=0.
- Memory read latency is the memory's; the arbiter adds no pipeline stage.
- Request dropping and re-raising in the same cycle is not possible. A drop is seen at the next edge, and the grant falls one cycle later.
- Widths:
  - Addresses pass through unmodified; no wrap or decode is done here.
  - Address 9'd511 is forwarded as-is.

Decomposition:
- Package bus_pkg:
  - ADDR_W and DATA_W localparams.
  - bus_state_t enum logic [2:0] {IDLE, GRANT0, GRANT1}.
  - RW_READ=0 and RW_WRITE=1 constants.
- No sub-module: one always_ff for state/last and one always_comb for the mux and grants.

Test Plan:
- Reset asserted mid-GRANT0 with core0_rw=1 -> immediately state=0, grants=00, rw=0, RAM_address=0.
- core0_request=1 only, address 9'd504, rw=0, RAM_data_out=8'h04:
  - core0_grant=1 after one edge, state=1, RAM_address=504.
  - core0_data_out=8'h04, core1_data_out=0.
- Both cores request from IDLE after reset -> GRANT0 first.
  - core0 drops -> IDLE for one cycle -> GRANT1 (core1 still requesting).
  - Both request again -> GRANT0 (round-robin).
- core1 granted, core1_rw=1, address 9'd503, data 8'h01 -> rw=1, RAM_address=503, RAM_data_in=8'h01; core0 inputs ignored.
- core0 holds request for 100 cycles while core1 requests -> core0_grant stays 1 throughout, core1_grant stays 0.
- Neither core requests for 50 cycles -> state stays IDLE, rw stays 0, grants 00.
